// File: rtl/cpu_cfg_table_pkg.sv
// Purpose: shared definitions for the per-VPI cell config table (cell word, bus modes, FSM states).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: CellCfgType (FWD bitmap + rewrite VPI), CW, BUS_INTEL/BUS_MOTOROLA,
//           state_e FSM encoding, WRCNT_ADDR (used only when CPU_CFG_WRCNT_EN is defined).
package cpu_cfg_table_pkg;

  localparam int NumTx = 4;

  // One table entry: per-port forward bitmap plus the VPI written into forwarded cells.
  typedef struct packed {
    logic [NumTx-1:0] fwd;
    logic [11:0]      vpi;
  } CellCfgType;

  localparam int CW = $bits(CellCfgType);

  localparam logic BUS_INTEL    = 1'b1;
  localparam logic BUS_MOTOROLA = 1'b0;

  localparam logic [11:0] WRCNT_ADDR = 12'h100;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ACK    = 2'd3
  } state_e;

endpackage

// File: rtl/cpu_bus_decode.sv
// Purpose: decodes the dual-mode (Intel/Motorola) CPU bus strobes and drives the ack pin polarity.
// Latency: combinational, zero cycles.
// Backpressure: none; the ack pin is simply the FSM ack re-encoded for the current bus mode.
// Ports: BusMode/Sel/Rd_DS/Wr_RW bus pins in, ack in; rd/wr strobes and Rdy_Dtack pin out.
module cpu_bus_decode
  import cpu_cfg_table_pkg::*;
(
  input  logic BusMode,
  input  logic Sel,
  input  logic Rd_DS,
  input  logic Wr_RW,
  input  logic ack,
  output logic rd,
  output logic wr,
  output logic Rdy_Dtack
);

  always_comb begin
    if (BusMode == BUS_INTEL) begin
      // Separate RD_n / WR_n strobes.
      rd = ~Sel & ~Rd_DS;
      wr = ~Sel & ~Wr_RW;
    end else begin
      // Single DS_n strobe qualified by R/W.
      rd = ~Sel & ~Rd_DS &  Wr_RW;
      wr = ~Sel & ~Rd_DS & ~Wr_RW;
    end
  end

  // Intel RDY is active high, Motorola DTACK_n is active low.
  assign Rdy_Dtack = (BusMode == BUS_INTEL) ? ack : ~ack;

endmodule

// File: rtl/cpu_cfg_table.sv
// Purpose: per-VPI cell forwarding/rewrite table with a CPU-bus access port and a lookup port.
// Latency: lookup result 1 cycle after lkp_req; CPU ack 2 cycles after the strobe is first sampled.
// Backpressure: CPU is held via RDY/DTACK until the strobe releases; lookups are accepted every cycle.
// Ports: clk, rst_n (sync, active low); CPU bus BusMode/Addr/Sel/DataIn/DataOut/Rd_DS/Wr_RW/Rdy_Dtack;
//        lookup lkp_req/lkp_vpi -> lkp_valid/lkp_cfg; init_done after the post-reset clear sweep.
// Option: define CPU_CFG_WRCNT_EN to add a saturating write counter at Addr 12'h100.
module cpu_cfg_table
  import cpu_cfg_table_pkg::*;
#(
  parameter int Depth = 256
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        BusMode,
  input  logic [11:0] Addr,
  input  logic        Sel,
  input  CellCfgType  DataIn,
  output CellCfgType  DataOut,
  input  logic        Rd_DS,
  input  logic        Wr_RW,
  output logic        Rdy_Dtack,
  input  logic        lkp_req,
  input  logic [7:0]  lkp_vpi,
  output logic        lkp_valid,
  output CellCfgType  lkp_cfg,
  output logic        init_done
);

  localparam int AW = $clog2(Depth);

  state_e        state;
  logic [AW-1:0] sweep;
  logic [11:0]   addr_q;
  logic          is_wr_q;
  logic          rd;
  logic          wr;
  logic          ack;
  logic          strobe_held;
  logic          in_range;
  logic          tbl_we;
  logic [AW-1:0] tbl_wa;
  CellCfgType    tbl_wd;
  CellCfgType    rd_data;
  CellCfgType    mem [Depth];

  cpu_bus_decode u_dec (
    .BusMode   (BusMode),
    .Sel       (Sel),
    .Rd_DS     (Rd_DS),
    .Wr_RW     (Wr_RW),
    .ack       (ack),
    .rd        (rd),
    .wr        (wr),
    .Rdy_Dtack (Rdy_Dtack)
  );

  assign ack         = (state == ST_ACK);
  assign in_range    = (addr_q[11:8] == 4'd0);
  // The ack is held only while the strobe of the latched access type stays asserted.
  assign strobe_held = is_wr_q ? wr : rd;

  // Single table write port shared by the clear sweep and CPU writes.
  always_comb begin
    tbl_we = 1'b0;
    tbl_wa = addr_q[AW-1:0];
    tbl_wd = DataIn;
    if (state == ST_INIT) begin
      tbl_we = 1'b1;
      tbl_wa = sweep;
      tbl_wd = CellCfgType'('0);
    end else if (state == ST_ACCESS && is_wr_q && in_range) begin
      tbl_we = 1'b1;
    end
  end

  // Gated by rst_n so a write caught by reset mid-access is not committed.
  always_ff @(posedge clk) begin
    if (tbl_we && rst_n) begin
      mem[tbl_wa] <= tbl_wd;
    end
  end

`ifdef CPU_CFG_WRCNT_EN
  logic [CW-1:0] wrcnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrcnt <= '0;
    end else if (state == ST_ACCESS && is_wr_q) begin
      if (addr_q == WRCNT_ADDR) begin
        wrcnt <= '0;
      end else if (in_range && (wrcnt != '1)) begin
        wrcnt <= wrcnt + 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = CellCfgType'('0);
    if (addr_q == WRCNT_ADDR) begin
      rd_data = CellCfgType'(wrcnt);
    end else if (in_range) begin
      rd_data = mem[addr_q[AW-1:0]];
    end
  end
`else
  always_comb begin
    rd_data = CellCfgType'('0);
    if (in_range) begin
      rd_data = mem[addr_q[AW-1:0]];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      sweep     <= '0;
      init_done <= 1'b0;
      addr_q    <= '0;
      is_wr_q   <= 1'b0;
      DataOut   <= CellCfgType'('0);
    end else begin
      case (state)
        ST_INIT: begin
          sweep <= sweep + 1'b1;
          if (sweep == AW'(Depth - 1)) begin
            init_done <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (rd || wr) begin
            is_wr_q <= wr;  // write wins if both Intel strobes are low
            addr_q  <= Addr;
            state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!is_wr_q) begin
            DataOut <= rd_data;
          end
          state <= ST_ACK;
        end
        ST_ACK: begin
          if (!strobe_held) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Registered read: a same-cycle CPU write to the same entry is seen by the next lookup.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lkp_valid <= 1'b0;
      lkp_cfg   <= CellCfgType'('0);
    end else begin
      lkp_valid <= lkp_req;
      if (lkp_req) begin
        lkp_cfg <= (state == ST_INIT) ? CellCfgType'('0) : mem[lkp_vpi];
      end
    end
  end

endmodule

// File: tb/tb_cpu_cfg_table.sv
// Purpose: self-checking bench for cpu_cfg_table; directed CPU and lookup traffic with a scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_cpu_cfg_table;
  import cpu_cfg_table_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          BusMode = 1'b1;
  logic [11:0]   Addr = '0;
  logic          Sel = 1'b1;
  logic [CW-1:0] DataIn = '0;
  logic [CW-1:0] DataOut;
  logic          Rd_DS = 1'b1;
  logic          Wr_RW = 1'b1;
  logic          Rdy_Dtack;
  logic          lkp_req = 1'b0;
  logic [7:0]    lkp_vpi = '0;
  logic          lkp_valid;
  logic [CW-1:0] lkp_cfg;
  logic          init_done;

  always #5 clk = ~clk;

  cpu_cfg_table dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .BusMode   (BusMode),
    .Addr      (Addr),
    .Sel       (Sel),
    .DataIn    (DataIn),
    .DataOut   (DataOut),
    .Rd_DS     (Rd_DS),
    .Wr_RW     (Wr_RW),
    .Rdy_Dtack (Rdy_Dtack),
    .lkp_req   (lkp_req),
    .lkp_vpi   (lkp_vpi),
    .lkp_valid (lkp_valid),
    .lkp_cfg   (lkp_cfg),
    .init_done (init_done)
  );

  typedef struct packed {
    logic          is_rd;
    logic [CW-1:0] data;
  } cpu_exp_t;

  logic [CW-1:0] lkp_q[$];
  cpu_exp_t      cpu_q[$];
  cpu_exp_t      cur;
  int            checks = 0;
  int            errors = 0;
  logic          prev_ack = 1'b0;
  logic          ack_now;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic ack_seen();
    return BusMode ? Rdy_Dtack : ~Rdy_Dtack;
  endfunction

  // Monitor: pops expected lookup results and CPU read data when the DUT presents them.
  always @(negedge clk) begin
    ack_now = BusMode ? Rdy_Dtack : ~Rdy_Dtack;
    if (lkp_valid === 1'b1) begin
      if (lkp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL lkp_unexpected: got valid with cfg %h, required no result", lkp_cfg);
      end else begin
        chk("lkp_cfg", lkp_cfg, lkp_q.pop_front());
      end
    end
    if (ack_now === 1'b1 && prev_ack === 1'b0) begin
      if (cpu_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ack_unexpected: got ack with no access pending, required none");
      end else begin
        cur = cpu_q.pop_front();
        if (cur.is_rd) chk("cpu_rd_data", DataOut, cur.data);
      end
    end
    prev_ack = ack_now;
  end

  task automatic lookup(input logic [7:0] vpi, input logic [CW-1:0] exp);
    @(posedge clk); #2;
    lkp_req = 1'b1;
    lkp_vpi = vpi;
    lkp_q.push_back(exp);
    @(posedge clk); #2;
    lkp_req = 1'b0;
  endtask

  task automatic strobe_on(input logic mode, input logic is_wr);
    Sel = 1'b0;
    if (mode == BUS_INTEL) begin
      if (is_wr) Wr_RW = 1'b0;
      else       Rd_DS = 1'b0;
    end else begin
      Wr_RW = ~is_wr;
      Rd_DS = 1'b0;
    end
  endtask

  task automatic strobe_off();
    Sel   = 1'b1;
    Rd_DS = 1'b1;
    Wr_RW = 1'b1;
  endtask

  // Full CPU cycle: strobe, wait (bounded) for ack, release, confirm ack drops.
  task automatic cpu_access(input logic mode, input logic is_wr, input logic [11:0] a,
                            input logic [CW-1:0] d, input logic [CW-1:0] exp, input string name);
    int n;
    @(posedge clk); #2;
    BusMode = mode;
    Addr    = a;
    DataIn  = d;
    cpu_q.push_back('{is_rd: ~is_wr, data: exp});
    strobe_on(mode, is_wr);
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (ack_seen() !== 1'b1 && n < 20);
    chk({name, "_ack_latency"}, n, 2);
    chk({name, "_pin_active"}, Rdy_Dtack, mode ? 32'd1 : 32'd0);
    @(posedge clk); #2;
    strobe_off();
    @(posedge clk);
    @(negedge clk);
    chk({name, "_pin_idle"}, Rdy_Dtack, mode ? 32'd0 : 32'd1);
  endtask

  // Called just after rst_n is released; counts edges to init_done and probes lookups mid-sweep.
  task automatic init_sweep(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
      #1;
      if (n == 20) begin
        lkp_req = 1'b1;
        lkp_vpi = 8'h00;
        lkp_q.push_back('0);
      end else if (n == 21) begin
        lkp_vpi = 8'hFF;
        lkp_q.push_back('0);
      end else if (n == 22) begin
        lkp_req = 1'b0;
      end
    end while (init_done !== 1'b1 && n < 300);
    chk({name, "_init_cycles"}, n, 256);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dataout", DataOut, 0);
    chk("rst_lkp_valid", lkp_valid, 0);
    chk("rst_lkp_cfg", lkp_cfg, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_rdy_intel", Rdy_Dtack, 0);
    BusMode = BUS_MOTOROLA;
    #1;
    chk("rst_dtack_moto", Rdy_Dtack, 1);
    BusMode = BUS_INTEL;

    @(posedge clk); #2;
    rst_n = 1'b1;
    init_sweep("first");
    lookup(8'h00, 16'h0000);
    lookup(8'hFF, 16'h0000);

    cpu_access(BUS_INTEL, 1'b1, 12'h012, 16'hA5C3, 16'h0000, "intel_wr");
    cpu_access(BUS_INTEL, 1'b0, 12'h012, 16'h0000, 16'hA5C3, "intel_rd");
    lookup(8'h12, 16'hA5C3);

    cpu_access(BUS_MOTOROLA, 1'b1, 12'h0FF, 16'h1234, 16'h0000, "moto_wr");
    cpu_access(BUS_MOTOROLA, 1'b0, 12'h0FF, 16'h0000, 16'h1234, "moto_rd");
    lookup(8'hFF, 16'h1234);

    cpu_access(BUS_INTEL, 1'b0, 12'h345, 16'h0000, 16'h0000, "oor_rd");
    cpu_access(BUS_INTEL, 1'b1, 12'h345, 16'hFFFF, 16'h0000, "oor_wr");
    lookup(8'h45, 16'h0000);
    cpu_access(BUS_INTEL, 1'b0, 12'h045, 16'h0000, 16'h0000, "oor_alias_rd");
    lookup(8'h12, 16'hA5C3);
    lookup(8'hFF, 16'h1234);

    // Lookup of 0x20 lands on the same edge as the CPU write's ACCESS cycle.
    fork
      cpu_access(BUS_INTEL, 1'b1, 12'h020, 16'h000F, 16'h0000, "coll_wr");
      begin
        @(posedge clk);
        lookup(8'h20, 16'h0000);
      end
    join
    lookup(8'h20, 16'h000F);

    // Reset arrives while a write is being acked.
    @(posedge clk); #2;
    BusMode = BUS_INTEL;
    Addr    = 12'h030;
    DataIn  = 16'hBEEF;
    cpu_q.push_back('{is_rd: 1'b0, data: 16'h0000});
    strobe_on(BUS_INTEL, 1'b1);
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (ack_seen() !== 1'b1 && n < 20);
    chk("rstack_ack_seen", ack_seen(), 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rstack_ack_drop", Rdy_Dtack, 0);
    chk("rstack_init_done_low", init_done, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    strobe_off();
    init_sweep("rerun");
    lookup(8'h30, 16'h0000);
    lookup(8'h12, 16'h0000);
    lookup(8'h20, 16'h0000);

`ifdef CPU_CFG_WRCNT_EN
    cpu_access(BUS_INTEL, 1'b1, 12'h001, 16'h1111, 16'h0000, "cnt_wr1");
    cpu_access(BUS_INTEL, 1'b1, 12'h002, 16'h2222, 16'h0000, "cnt_wr2");
    cpu_access(BUS_MOTOROLA, 1'b1, 12'h003, 16'h3333, 16'h0000, "cnt_wr3");
    cpu_access(BUS_INTEL, 1'b0, 12'h100, 16'h0000, 16'h0003, "cnt_rd3");
    cpu_access(BUS_INTEL, 1'b1, 12'h100, 16'hABCD, 16'h0000, "cnt_clr");
    cpu_access(BUS_INTEL, 1'b0, 12'h100, 16'h0000, 16'h0000, "cnt_rd0");
    lookup(8'h02, 16'h2222);
`else
    cpu_access(BUS_INTEL, 1'b1, 12'h100, 16'h5555, 16'h0000, "nocnt_wr");
    cpu_access(BUS_INTEL, 1'b0, 12'h100, 16'h0000, 16'h0000, "nocnt_rd");
    lookup(8'h00, 16'h0000);
`endif

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("lkp_q_drained", lkp_q.size(), 0);
    chk("cpu_q_drained", cpu_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
